// File: rtl/pattern_search_engine.sv
// Memory-mapped 5-bit pattern counter: scans a 32-byte message, counts pattern hits
// (in-byte, bytes-with-hit, all 252 windows) and writes the three totals back.
module pattern_search_engine #(
    parameter int MSG_BASE = 0,
    parameter int PAT_ADDR = 32,
    parameter int RES_ADDR = 33,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [7:0]    mem_rdata,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_PAT,
        SCAN,
        WR_CTB,
        WR_CTO,
        WR_CTS,
        DONE
    } state_t;

    localparam logic [AW-1:0] MSG_A = AW'(MSG_BASE);
    localparam logic [AW-1:0] PAT_A = AW'(PAT_ADDR);
    localparam logic [AW-1:0] RES_A = AW'(RES_ADDR);

    state_t      state;
    logic        armed;
    logic [5:0]  k;
    logic [4:0]  pat;
    logic [7:0]  prev;
    logic [7:0]  ctb;
    logic [7:0]  cto;
    logic [7:0]  cts;

    logic [2:0]  in_cnt;
    logic [2:0]  cross_cnt;
    logic [11:0] win;
    logic [7:0]  ctb_next;
    logic [7:0]  cto_next;
    logic [7:0]  cts_next;

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        in_cnt    = 3'd0;
        cross_cnt = 3'd0;
        win       = {prev[3:0], mem_rdata};
        for (int i = 0; i < 4; i++) begin
            if (mem_rdata[i +: 5] == pat) in_cnt = in_cnt + 3'd1;
            if (win[i + 4 +: 5] == pat)   cross_cnt = cross_cnt + 3'd1;
        end
        // Message byte 0 has no predecessor, so no crossing windows.
        if (k < 6'd2) cross_cnt = 3'd0;
        ctb_next = ctb + {5'd0, in_cnt};
        cto_next = cto + {7'd0, (in_cnt != 3'd0)};
        cts_next = cts + {5'd0, in_cnt} + {5'd0, cross_cnt};
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            armed     <= 1'b0;
            k         <= 6'd0;
            pat       <= 5'd0;
            prev      <= 8'd0;
            ctb       <= 8'd0;
            cto       <= 8'd0;
            cts       <= 8'd0;
            done      <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= 8'd0;
        end else begin
            // armed blocks a start that coincides with reset release.
            armed <= 1'b1;
            unique case (state)
                IDLE, DONE: begin
                    if (start && armed) begin
                        state     <= RD_PAT;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        k         <= 6'd0;
                        ctb       <= 8'd0;
                        cto       <= 8'd0;
                        cts       <= 8'd0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= PAT_A;
                    end
                end
                RD_PAT: begin
                    state     <= SCAN;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= MSG_A;
                end
                SCAN: begin
                    if (k == 6'd0) begin
                        pat <= mem_rdata[4:0];
                    end else begin
                        ctb  <= ctb_next;
                        cto  <= cto_next;
                        cts  <= cts_next;
                        prev <= mem_rdata;
                    end
                    k <= k + 6'd1;
                    if (k == 6'd32) begin
                        state     <= WR_CTB;
                        mem_wr_en <= 1'b1;
                        mem_addr  <= RES_A;
                        mem_wdata <= ctb_next;
                    end else if (k == 6'd31) begin
                        mem_rd_en <= 1'b0;
                    end else begin
                        mem_addr <= MSG_A + AW'(k) + AW'(1);
                    end
                end
                WR_CTB: begin
                    state     <= WR_CTO;
                    mem_addr  <= RES_A + AW'(1);
                    mem_wdata <= cto;
                end
                WR_CTO: begin
                    state     <= WR_CTS;
                    mem_addr  <= RES_A + AW'(2);
                    mem_wdata <= cts;
                end
                WR_CTS: begin
                    state     <= DONE;
                    mem_wr_en <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_search_engine.sv
// Self-checking bench: a byte memory model around the engine, directed cases from the
// protocol description plus randomized messages checked against a bit-string window count.
module tb_pattern_search_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       done;
    logic       busy;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;

    pattern_search_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    // Memory image: message bytes 0..31, pattern byte at 32, results at 33..35.
    logic [7:0] msg [32];
    logic [7:0] pat_byte;
    logic [7:0] res [3];
    int checks = 0;
    int errors = 0;
    int write_cnt = 0;
    int bad_writes = 0;
    int overlap_cnt = 0;

    always @(posedge clk) begin
        if (mem_wr_en) begin
            write_cnt <= write_cnt + 1;
            if (mem_addr >= 8'd33 && mem_addr <= 8'd35) res[mem_addr - 8'd33] <= mem_wdata;
            else bad_writes <= bad_writes + 1;
        end
        if (mem_rd_en) begin
            if (mem_addr < 8'd32)       mem_rdata <= msg[mem_addr[4:0]];
            else if (mem_addr == 8'd32) mem_rdata <= pat_byte;
            else                        mem_rdata <= 8'hEE;
        end
    end

    always @(negedge clk) if (mem_rd_en && mem_wr_en) overlap_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: count 5-bit windows over the 256-bit MSB-first string.
    function automatic void model(output int ctb, output int cto, output int cts);
        logic [255:0] s;
        bit hit [32];
        for (int i = 0; i < 32; i++) begin
            s[255 - 8 * i -: 8] = msg[i];
            hit[i] = 1'b0;
        end
        ctb = 0;
        cto = 0;
        cts = 0;
        for (int p = 0; p < 252; p++) begin
            if (s[255 - p -: 5] == pat_byte[4:0]) begin
                cts++;
                if (p % 8 <= 3) begin
                    ctb++;
                    hit[p / 8] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 32; i++) if (hit[i]) cto++;
    endfunction

    // Runs one request; called #1 after a rising edge. hold = cycles start stays high,
    // glitch = cycle at which a one-cycle stray start is injected (0 = none).
    task automatic do_run(input string tag, input int hold, input int glitch,
                          input bit use_model, input int e0, input int e1, input int e2);
        int cycles;
        int w0;
        int x0, x1, x2;
        w0 = write_cnt;
        if (use_model) model(x0, x1, x2);
        else begin
            x0 = e0; x1 = e1; x2 = e2;
        end
        start  = 1'b1;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == hold) start = 1'b0;
            if (glitch > 0 && cycles == glitch) start = 1'b1;
            if (glitch > 0 && cycles == glitch + 1) start = 1'b0;
            if (cycles == 1) begin
                check({tag, "_done_drop"}, {31'd0, done}, 0);
                check({tag, "_busy"}, {31'd0, busy}, 1);
            end
        end while (!done && cycles < 100);
        start = 1'b0;
        check({tag, "_latency"}, cycles, 38);
        check({tag, "_ctb"}, {24'd0, res[0]}, x0);
        check({tag, "_cto"}, {24'd0, res[1]}, x1);
        check({tag, "_cts"}, {24'd0, res[2]}, x2);
        check({tag, "_writes"}, write_cnt - w0, 3);
        check({tag, "_bad_writes"}, bad_writes, 0);
    endtask

    initial begin
        int cycles;
        int w0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", {31'd0, done}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_rd_en", {31'd0, mem_rd_en}, 0);
        check("rst_wr_en", {31'd0, mem_wr_en}, 0);
        check("rst_addr", {24'd0, mem_addr}, 0);
        check("rst_wdata", {24'd0, mem_wdata}, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // All-zero message, zero pattern: every window matches
        for (int i = 0; i < 32; i++) msg[i] = 8'h00;
        pat_byte = 8'h00;
        do_run("zeros", 1, 0, 1'b0, 128, 32, 252);

        // Alternating bits, pattern 10101
        for (int i = 0; i < 32; i++) msg[i] = 8'h55;
        pat_byte = 8'h15;
        do_run("alt55", 1, 0, 1'b0, 64, 32, 126);

        // Single crossing-only match; upper pattern bits must be ignored
        for (int i = 0; i < 32; i++) msg[i] = 8'h00;
        msg[0] = 8'h01;
        msg[1] = 8'hC0;
        pat_byte = 8'hE7;
        do_run("cross", 1, 0, 1'b0, 0, 0, 1);

        // Back-to-back from DONE with a different pattern
        pat_byte = 8'h00;
        do_run("b2b", 1, 0, 1'b1, 0, 0, 0);

        // Start held for several cycles, then a stray start during SCAN
        for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
        pat_byte = 8'($urandom);
        do_run("hold", 6, 0, 1'b1, 0, 0, 0);
        do_run("glitch", 1, 14, 1'b1, 0, 0, 0);

        // Reset in the middle of SCAN (k = 10) aborts without writes
        w0 = write_cnt;
        start = 1'b1;
        cycles = 0;
        while (cycles < 12) begin
            @(posedge clk);
            #1;
            cycles++;
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("abort_done", {31'd0, done}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_strobes", {30'd0, mem_rd_en, mem_wr_en}, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        check("abort_writes", write_cnt - w0, 0);
        check("abort_idle_done", {31'd0, done}, 0);
        pat_byte = 8'h0B;
        do_run("after_abort", 1, 0, 1'b1, 0, 0, 0);

        // Randomized messages with a mix of dense, sparse and uniform bytes
        for (int n = 0; n < 500; n++) begin
            int mode;
            mode = $urandom_range(0, 3);
            for (int i = 0; i < 32; i++) begin
                case (mode)
                    0: msg[i] = 8'($urandom);
                    1: msg[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                    2: msg[i] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
                    default: msg[i] = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'h55;
                endcase
            end
            pat_byte = 8'($urandom);
            do_run("rand", 1, 0, 1'b1, 0, 0, 0);
        end

        check("strobe_overlap", overlap_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
